xcorr_lag_search: RTL and testbench

Multi-channel successor to the single-pair PHAT lag stage. Takes framed cross-correlation (IFFT-order) samples for NUM_CH microphone pairs and scans each frame for its peak inside a programmable lag window. Emits one signed lag per pair over a valid/ready handshake. Sits between the PHAT IFFT output and the position solver. Replaces the fixed 33-sample FIFO trigger with a length-checked streaming scan.

---
 rtl/phat_pkg.sv | 24 ++
 rtl/xcorr_lag_search_if.sv | 37 +++
 rtl/xcorr_peak_cmp.sv | 77 +++++++
 rtl/xcorr_lag_search.sv | 169 ++++++++++++++++
 tb/tb_xcorr_lag_search.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phat_pkg.sv
// Shared definitions for the PHAT lag search: FSM state codes, compare-mode
// enumeration and the IFFT-order index to signed lag conversion.
package phat_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_SCAN = 2'd0;
    localparam logic [1:0] ST_DROP = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    // Peak compare mode: largest signed value or largest magnitude
    typedef enum int unsigned {
        MODE_SIGNED = 0,
        MODE_ABS    = 1
    } abs_mode_e;

    // IFFT ordering: the upper half of the frame holds the negative lags
    function automatic int idx_to_lag(input int unsigned k, input int unsigned frame_len);
        if (k < frame_len / 2) begin
            return int'(k);
        end
        return int'(k) - int'(frame_len);
    endfunction

endpackage

// File: rtl/xcorr_lag_search_if.sv
// Sample stream and result stream of the lag search block.
//   in_valid/in_ready/in_data/in_last : framed xcorr samples, index 0 first
//   peak_thresh                       : confidence threshold
//   res_valid/res_ready               : result handshake
//   res_ch/lag_diff/peak_val/res_conf/res_len_err/set_done : result payload
// master = sample source and result sink, slave = the lag search block.
interface xcorr_lag_search_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LAG_W  = 6,
    parameter int unsigned CH_W   = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [DATA_W-1:0] peak_thresh;
    logic              res_valid;
    logic              res_ready;
    logic [CH_W-1:0]   res_ch;
    logic [LAG_W-1:0]  lag_diff;
    logic [DATA_W-1:0] peak_val;
    logic              res_conf;
    logic              res_len_err;
    logic              set_done;

    modport master (
        output in_valid, in_data, in_last, peak_thresh, res_ready,
        input  in_ready, res_valid, res_ch, lag_diff, peak_val, res_conf,
               res_len_err, set_done
    );

    modport slave (
        input  in_valid, in_data, in_last, peak_thresh, res_ready,
        output in_ready, res_valid, res_ch, lag_diff, peak_val, res_conf,
               res_len_err, set_done
    );
endinterface

// File: rtl/xcorr_peak_cmp.sv
// Windowed running-peak tracker.
//   clk, rst_n   : clock, async active-low reset
//   sample_en    : a sample is transferring this cycle
//   sample, idx  : sample value and its frame index
//   clear        : drop the running best (start of a new frame)
//   best_val_c   : best compare value including the current sample
//   best_idx_c   : frame index of best_val_c
module xcorr_peak_cmp
    import phat_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned LAG_W     = 6,
    parameter int unsigned MAX_LAG   = 16,
    parameter int unsigned ABS_MODE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] sample,
    input  logic [LAG_W-1:0]  idx,
    input  logic              clear,
    output logic [DATA_W-1:0] best_val_c,
    output logic [LAG_W-1:0]  best_idx_c
);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] cmp_val;
    logic [DATA_W-1:0] best_val;
    logic [LAG_W-1:0]  best_idx;
    logic              have_best;
    logic              in_win;
    logic              upd;
    int                lag;

    // Compare value; magnitude of the most negative sample saturates
    always_comb begin
        cmp_val = sample;
        if (ABS_MODE == 32'(MODE_ABS) && sample[DATA_W-1]) begin
            if (sample == MOST_NEG) begin
                cmp_val = MOST_POS;
            end else begin
                cmp_val = (~sample) + ONE;
            end
        end
    end

    // Window test and strict-greater update (earliest index wins ties)
    always_comb begin
        lag        = idx_to_lag(32'(idx), FRAME_LEN);
        in_win     = (lag <= int'(MAX_LAG)) && (lag >= -int'(MAX_LAG));
        upd        = sample_en && in_win &&
                     (!have_best || ($signed(cmp_val) > $signed(best_val)));
        best_val_c = upd ? cmp_val : best_val;
        best_idx_c = upd ? idx : best_idx;
    end

    // Running best register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_val  <= '0;
            best_idx  <= '0;
            have_best <= 1'b0;
        end else if (clear) begin
            best_val  <= '0;
            best_idx  <= '0;
            have_best <= 1'b0;
        end else if (upd) begin
            best_val  <= cmp_val;
            best_idx  <= idx;
            have_best <= 1'b1;
        end
    end

endmodule

// File: rtl/xcorr_lag_search.sv
// Multi-channel cross-correlation lag search. Scans each framed xcorr for
// its peak inside +/-MAX_LAG and returns one signed lag per mic pair.
//   clk, rst_n : clock, async active-low reset
//   bus        : sample stream in, result stream out (slave view)
module xcorr_lag_search
    import phat_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned LAG_W     = 6,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned MAX_LAG   = 16,
    parameter int unsigned ABS_MODE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    xcorr_lag_search_if.slave bus
);
    localparam int unsigned      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [LAG_W-1:0] LAST_IDX = LAG_W'(FRAME_LEN - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    logic [1:0]        state_q, state_d;
    logic [LAG_W-1:0]  idx_q, idx_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              drop_q, drop_d;
    logic              in_ready_q, in_ready_d;
    logic              res_valid_q, res_valid_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;
    logic [LAG_W-1:0]  lag_q, lag_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic              conf_q, conf_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic              xfer;
    logic              sample_en;
    logic              clear_best;
    logic [DATA_W-1:0] best_val_c;
    logic [LAG_W-1:0]  best_idx_c;

    xcorr_peak_cmp #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .LAG_W     (LAG_W),
        .MAX_LAG   (MAX_LAG),
        .ABS_MODE  (ABS_MODE)
    ) u_peak_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .sample     (bus.in_data),
        .idx        (idx_q),
        .clear      (clear_best),
        .best_val_c (best_val_c),
        .best_idx_c (best_idx_c)
    );

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ch_d        = ch_q;
        drop_d      = drop_q;
        res_valid_d = res_valid_q;
        res_ch_d    = res_ch_q;
        lag_d       = lag_q;
        peak_d      = peak_q;
        conf_d      = conf_q;
        err_d       = err_q;
        done_d      = done_q;
        clear_best  = 1'b0;
        sample_en   = 1'b0;
        xfer        = bus.in_valid && in_ready_q;

        case (state_q)
            ST_SCAN: begin
                if (xfer) begin
                    sample_en = 1'b1;
                    if (bus.in_last || idx_q == LAST_IDX) begin
                        state_d     = ST_EMIT;
                        idx_d       = '0;
                        res_valid_d = 1'b1;
                        res_ch_d    = ch_q;
                        done_d      = (ch_q == LAST_CH);
                        if (bus.in_last && idx_q != LAST_IDX) begin
                            // short frame carries no usable peak
                            err_d  = 1'b1;
                            drop_d = 1'b0;
                            lag_d  = '0;
                            peak_d = '0;
                            conf_d = 1'b0;
                        end else begin
                            // full frame, or long frame whose tail is dropped
                            err_d  = !bus.in_last;
                            drop_d = !bus.in_last;
                            lag_d  = LAG_W'(idx_to_lag(32'(best_idx_c), FRAME_LEN));
                            peak_d = best_val_c;
                            conf_d = (best_val_c >= bus.peak_thresh);
                        end
                    end else begin
                        idx_d = idx_q + LAG_W'(1);
                    end
                end
            end
            ST_DROP: begin
                if (xfer && bus.in_last) begin
                    state_d = ST_SCAN;
                end
            end
            ST_EMIT: begin
                if (bus.res_ready) begin
                    state_d     = drop_q ? ST_DROP : ST_SCAN;
                    drop_d      = 1'b0;
                    res_valid_d = 1'b0;
                    clear_best  = 1'b1;
                    ch_d        = (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase

        // ready is registered, so res_ready never reaches in_ready combinationally
        in_ready_d = (state_d != ST_EMIT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            idx_q       <= '0;
            ch_q        <= '0;
            drop_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            lag_q       <= '0;
            peak_q      <= '0;
            conf_q      <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ch_q        <= ch_d;
            drop_q      <= drop_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            lag_q       <= lag_d;
            peak_q      <= peak_d;
            conf_q      <= conf_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_ch      = res_ch_q;
    assign bus.lag_diff    = lag_q;
    assign bus.peak_val    = peak_q;
    assign bus.res_conf    = conf_q;
    assign bus.res_len_err = err_q;
    assign bus.set_done    = done_q;

endmodule

// File: tb/tb_xcorr_lag_search.sv
// Directed bench for xcorr_lag_search: a signed-mode 4-channel instance and a
// magnitude-mode 1-channel instance share one stimulus driver, selected by sel.
module tb_xcorr_lag_search;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        drv_valid = 1'b0;
    logic        drv_last = 1'b0;
    logic        drv_ready = 1'b0;
    logic [31:0] drv_data = '0;
    logic [31:0] thresh = '0;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:127];

    xcorr_lag_search_if #(.DATA_W(32), .LAG_W(6), .CH_W(2)) sa ();
    xcorr_lag_search_if #(.DATA_W(32), .LAG_W(6), .CH_W(1)) ab ();

    assign sa.in_valid    = drv_valid & ~sel;
    assign sa.in_data     = drv_data;
    assign sa.in_last     = drv_last;
    assign sa.peak_thresh = thresh;
    assign sa.res_ready   = drv_ready & ~sel;
    assign ab.in_valid    = drv_valid & sel;
    assign ab.in_data     = drv_data;
    assign ab.in_last     = drv_last;
    assign ab.peak_thresh = thresh;
    assign ab.res_ready   = drv_ready & sel;

    xcorr_lag_search #(
        .DATA_W(32), .FRAME_LEN(64), .LAG_W(6), .NUM_CH(4), .MAX_LAG(16), .ABS_MODE(0)
    ) u_signed (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sa.slave)
    );

    xcorr_lag_search #(
        .DATA_W(32), .FRAME_LEN(64), .LAG_W(6), .NUM_CH(1), .MAX_LAG(16), .ABS_MODE(1)
    ) u_abs (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ab.slave)
    );

    // View of the selected instance
    logic        rdy, r_valid, r_conf, r_err, r_done;
    logic [1:0]  r_ch;
    logic [5:0]  r_lag;
    logic [31:0] r_peak;
    always_comb begin
        if (sel) begin
            rdy = ab.in_ready; r_valid = ab.res_valid; r_ch = {1'b0, ab.res_ch};
            r_lag = ab.lag_diff; r_peak = ab.peak_val; r_conf = ab.res_conf;
            r_err = ab.res_len_err; r_done = ab.set_done;
        end else begin
            rdy = sa.in_ready; r_valid = sa.res_valid; r_ch = sa.res_ch;
            r_lag = sa.lag_diff; r_peak = sa.peak_val; r_conf = sa.res_conf;
            r_err = sa.res_len_err; r_done = sa.set_done;
        end
    end

    // Captured result
    int          c_wait;
    logic        c_conf, c_err, c_done;
    logic [1:0]  c_ch;
    logic [5:0]  c_lag;
    logic [31:0] c_peak;

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < 128; i++) mem[i] = v;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        drv_valid = 1'b1; drv_data = d; drv_last = l;
        while (rdy !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        if (rdy !== 1'b1) begin
            total++; bad++;
            $display("FAIL push_timeout in_ready=%b required=1", rdy);
        end else begin
            @(posedge clk); #1;
        end
        drv_valid = 1'b0; drv_last = 1'b0;
    endtask

    task automatic send(input int first, input int last_k, input int last_at);
        for (int k = first; k <= last_k; k++) push(mem[k], k == last_at);
    endtask

    task automatic capture();
        int n;
        n = 0;
        while (r_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        c_wait = n;
        if (r_valid !== 1'b1) begin
            total++; bad++;
            $display("FAIL result_timeout res_valid=%b required=1", r_valid);
        end
        c_ch = r_ch; c_lag = r_lag; c_peak = r_peak;
        c_conf = r_conf; c_err = r_err; c_done = r_done;
    endtask

    task automatic ack();
        drv_ready = 1'b1;
        @(posedge clk); #1;
        drv_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [44:0] got;
        rst_n = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got = {sa.in_ready, sa.res_valid, sa.res_ch, sa.lag_diff, sa.peak_val,
               sa.res_conf, sa.res_len_err, sa.set_done};
        total++;
        if (got !== 45'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", got); end
        total++;
        if ({ab.in_ready, ab.res_valid} !== 2'b00) begin
            bad++; $display("FAIL reset_abs got=%b want=00", {ab.in_ready, ab.res_valid});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (sa.in_ready !== 1'b0) begin bad++; $display("FAIL ready_at_release got=%b want=0", sa.in_ready); end
        @(posedge clk); #1;
        total++;
        if ({sa.in_ready, ab.in_ready} !== 2'b11) begin
            bad++; $display("FAIL ready_after_release got=%b want=11", {sa.in_ready, ab.in_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [42:0] got, want;
        sel = 1'b0; thresh = 32'd0;
        for (int i = 0; i < 5; i++) begin
            fill(32'd0);
            mem[i + 1] = 32'(100 * (i + 1));
            send(0, 63, 63);
            capture();
            got  = {c_ch, c_lag, c_peak, c_conf, c_err, c_done};
            want = {2'(i % 4), 6'(i + 1), 32'(100 * (i + 1)), 1'b1, 1'b0, 1'(i % 4 == 3)};
            total++;
            if (got !== want) begin bad++; $display("FAIL b2b_frame%0d got=%h want=%h", i, got, want); end
            if (i == 1) begin
                for (int h = 0; h < 5; h++) begin
                    @(posedge clk); #1;
                    total++;
                    if ({rdy, r_valid, r_lag} !== {1'b0, 1'b1, 6'd2}) begin
                        bad++;
                        $display("FAIL b2b_hold%0d got=%b want=%b", h, {rdy, r_valid, r_lag}, {1'b0, 1'b1, 6'd2});
                    end
                end
            end
            ack();
            total++;
            if ({rdy, r_valid} !== 2'b10) begin
                bad++; $display("FAIL b2b_release%0d got=%b want=10", i, {rdy, r_valid});
            end
        end
    endtask

    task automatic test_signed_peak();
        logic [42:0] got, want;
        sel = 1'b0; thresh = 32'd500;
        fill(32'd0);
        mem[3] = 32'd1000;
        send(0, 63, 63);
        capture();
        total++;
        if (c_wait !== 0) begin bad++; $display("FAIL peak_latency got=%0d want=0", c_wait); end
        got  = {c_ch, c_lag, c_peak, c_conf, c_err, c_done};
        want = {2'd1, 6'd3, 32'd1000, 1'b1, 1'b0, 1'b0};
        total++;
        if (got !== want) begin bad++; $display("FAIL peak_plus3 got=%h want=%h", got, want); end
        ack();
        // all negative in window: first in-window sample seeds the best
        thresh = 32'd1000;
        fill(32'hFFFF_FFFB);
        mem[10] = 32'hFFFF_FFFD;
        mem[30] = 32'd100;
        send(0, 63, 63);
        capture();
        got  = {c_ch, c_lag, c_peak, c_conf, c_err, c_done};
        want = {2'd2, 6'd10, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0};
        total++;
        if (got !== want) begin bad++; $display("FAIL peak_negative got=%h want=%h", got, want); end
        ack();
    endtask

    task automatic test_window();
        logic [42:0] got, want;
        sel = 1'b0; thresh = 32'd1000;
        fill(32'd0);
        mem[62] = 32'd500;
        mem[40] = 32'd9000;
        send(0, 63, 63);
        capture();
        got  = {c_ch, c_lag, c_peak, c_conf, c_err, c_done};
        want = {2'd3, 6'h3E, 32'd500, 1'b0, 1'b0, 1'b1};
        total++;
        if (got !== want) begin bad++; $display("FAIL window_minus2 got=%h want=%h", got, want); end
        ack();
        fill(32'd0);
        mem[16] = 32'd10; mem[17] = 32'd20; mem[48] = 32'd30; mem[47] = 32'd40;
        send(0, 63, 63);
        capture();
        got  = {c_ch, c_lag, c_peak, c_conf, c_err, c_done};
        want = {2'd0, 6'h30, 32'd30, 1'b0, 1'b0, 1'b0};
        total++;
        if (got !== want) begin bad++; $display("FAIL window_edges got=%h want=%h", got, want); end
        ack();
    endtask

    task automatic test_short_long();
        logic [42:0] got, want;
        logic [10:0] gs;
        sel = 1'b0; thresh = 32'd0;
        fill(32'd0);
        mem[2] = 32'd50;
        send(0, 10, 10);
        capture();
        gs = {c_ch, c_lag, c_conf, c_err, c_done};
        total++;
        if (c_wait !== 0 || gs !== {2'd1, 6'd0, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL short_frame got=%h wait=%0d want=%h wait=0", gs, c_wait,
                            {2'd1, 6'd0, 1'b0, 1'b1, 1'b0});
        end
        ack();
        fill(32'd0);
        mem[5] = 32'd77;
        send(0, 63, -1);
        capture();
        got  = {c_ch, c_lag, c_peak, c_conf, c_err, c_done};
        want = {2'd2, 6'd5, 32'd77, 1'b1, 1'b1, 1'b0};
        total++;
        if (c_wait !== 0 || got !== want) begin
            bad++; $display("FAIL long_frame got=%h wait=%0d want=%h wait=0", got, c_wait, want);
        end
        ack();
        send(64, 69, 69);
        total++;
        if ({rdy, r_valid} !== 2'b10) begin
            bad++; $display("FAIL drop_tail got=%b want=10", {rdy, r_valid});
        end
        fill(32'd0);
        mem[7] = 32'd8;
        send(0, 63, 63);
        capture();
        got  = {c_ch, c_lag, c_peak, c_conf, c_err, c_done};
        want = {2'd3, 6'd7, 32'd8, 1'b1, 1'b0, 1'b1};
        total++;
        if (got !== want) begin bad++; $display("FAIL after_drop got=%h want=%h", got, want); end
        ack();
    endtask

    task automatic test_abs_mode();
        logic [42:0] got, want;
        sel = 1'b1; thresh = 32'd700;
        fill(32'd0);
        mem[5] = 32'hFFFF_FD44;
        mem[1] = 32'd600;
        send(0, 63, 63);
        capture();
        got  = {c_ch, c_lag, c_peak, c_conf, c_err, c_done};
        want = {2'd0, 6'd5, 32'd700, 1'b1, 1'b0, 1'b1};
        total++;
        if (got !== want) begin bad++; $display("FAIL abs_peak got=%h want=%h", got, want); end
        ack();
        thresh = 32'd301;
        fill(32'd0);
        mem[2] = 32'd300;
        mem[7] = 32'hFFFF_FED4;
        send(0, 63, 63);
        capture();
        got  = {c_ch, c_lag, c_peak, c_conf, c_err, c_done};
        want = {2'd0, 6'd2, 32'd300, 1'b0, 1'b0, 1'b1};
        total++;
        if (got !== want) begin bad++; $display("FAIL abs_tie got=%h want=%h", got, want); end
        ack();
        thresh = 32'h8000_0000;
        fill(32'd0);
        mem[4] = 32'h8000_0000;
        mem[6] = 32'h7FFF_FFFF;
        send(0, 63, 63);
        capture();
        got  = {c_ch, c_lag, c_peak, c_conf, c_err, c_done};
        want = {2'd0, 6'd4, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1};
        total++;
        if (got !== want) begin bad++; $display("FAIL abs_saturate got=%h want=%h", got, want); end
        ack();
        sel = 1'b0;
    endtask

    task automatic test_midframe_reset();
        logic [44:0] g0;
        logic [42:0] got, want;
        sel = 1'b0; thresh = 32'd0;
        fill(32'd0);
        mem[3] = 32'd9999;
        send(0, 19, -1);
        rst_n = 1'b0;
        #1;
        g0 = {sa.in_ready, sa.res_valid, sa.res_ch, sa.lag_diff, sa.peak_val,
              sa.res_conf, sa.res_len_err, sa.set_done};
        total++;
        if (g0 !== 45'd0) begin bad++; $display("FAIL midreset_outputs got=%h want=0", g0); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fill(32'd0);
        mem[9] = 32'd444;
        send(0, 63, 63);
        capture();
        got  = {c_ch, c_lag, c_peak, c_conf, c_err, c_done};
        want = {2'd0, 6'd9, 32'd444, 1'b1, 1'b0, 1'b0};
        total++;
        if (got !== want) begin bad++; $display("FAIL midreset_frame got=%h want=%h", got, want); end
        ack();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_signed_peak();
        test_window();
        test_short_long();
        test_abs_mode();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
